// File: rtl/div_iter_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) for the execute stage; drives the ALU stall.
// Optional DIV_FAST_BYPASS_EN: finish in one cycle when b == 0 or |a| < |b|.
module div_iter_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hold,
    input  logic             flush,
    output logic             stall,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] div_r;
    logic             q_neg;
    logic             r_neg;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH+1:0] diff;
    logic [WIDTH:0]   rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic             last;

    assign a_mag = (is_signed & a[WIDTH-1]) ? -a : a;
    assign b_mag = (is_signed & b[WIDTH-1]) ? -b : b;

    // stall is forced low while reset is asserted so the hazard unit never sees a stale stall
    assign stall = resetn & ~flush & (((state == IDLE) & start) | (state == BUSY));
    assign valid = (state == DONE);
    assign last  = (cnt == CNT_W'(WIDTH - 1));

`ifdef DIV_FAST_BYPASS_EN
    logic bypass;
    assign bypass = (b_mag == '0) | (a_mag < b_mag);
`endif

    // quo_r doubles as the dividend shift register; its MSB feeds the partial remainder
    always_comb begin
        diff   = {rem_r, quo_r[WIDTH-1]} - {2'b00, div_r};
        rem_nx = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
        quo_nx = {quo_r[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH+1]) begin
            rem_nx = diff[WIDTH:0];
            quo_nx = {quo_r[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            div_r     <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
`ifdef DIV_FAST_BYPASS_EN
                        if (bypass) begin
                            state     <= DONE;
                            quotient  <= (b == '0) ? '1 : '0;
                            remainder <= a;
                        end else begin
`else
                        begin
`endif
                            state <= BUSY;
                            cnt   <= '0;
                            rem_r <= '0;
                            quo_r <= a_mag;
                            div_r <= b_mag;
                            // divide-by-zero keeps the raw all-ones quotient
                            q_neg <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]) & (b != '0);
                            r_neg <= is_signed & a[WIDTH-1];
                        end
                    end
                end
                BUSY: begin
                    cnt   <= cnt + CNT_W'(1);
                    rem_r <= rem_nx;
                    quo_r <= quo_nx;
                    if (last) begin
                        state     <= DONE;
                        quotient  <= q_neg ? -quo_nx : quo_nx;
                        remainder <= r_neg ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];
                    end
                end
                DONE: begin
                    if (!hold) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed self-checking bench for div_iter_unit (WIDTH=32).
module tb_div_iter_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        hold;
    logic        flush;
    logic        stall;
    logic        valid;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int FULL = 33;
`ifdef DIV_FAST_BYPASS_EN
    localparam int FASTLAT = 1;
`else
    localparam int FASTLAT = 33;
`endif

    div_iter_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .resetn(resetn), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .hold(hold), .flush(flush),
        .stall(stall), .valid(valid), .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;

    // Called just after a posedge; returns at the negedge of the first non-stall cycle.
    task automatic run_div(input logic sg, input logic [31:0] av, input logic [31:0] bv,
                           output int sc);
        start = 1'b1; is_signed = sg; a = av; b = bv;
        sc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall) break;
            sc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic end_instr();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0; hold = 1'b0; flush = 1'b0;
        #2;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_checks++; if (quotient !== 32'h0) begin n_fail++; $display("FAIL reset_q: got %h want 0", quotient); end
        n_checks++; if (remainder !== 32'h0) begin n_fail++; $display("FAIL reset_r: got %h want 0", remainder); end
        #20 resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_divu_basic();
        int sc;
        run_div(1'b0, 32'd100, 32'd7, sc);
        n_checks++; if (sc !== FULL) begin n_fail++; $display("FAIL divu_lat: got %0d want %0d", sc, FULL); end
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL divu_valid: got %b want 1", valid); end
        n_checks++; if (quotient !== 32'd14) begin n_fail++; $display("FAIL divu_q: got %h want %h", quotient, 32'd14); end
        n_checks++; if (remainder !== 32'd2) begin n_fail++; $display("FAIL divu_r: got %h want %h", remainder, 32'd2); end
        end_instr();
        @(negedge clk);
        n_checks++; if (valid !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL divu_idle: got valid=%b stall=%b want 0 0", valid, stall); end
        @(posedge clk); #1;
    endtask

    task automatic test_div_signed();
        int sc;
        run_div(1'b1, 32'hFFFFFF9C, 32'd7, sc);
        n_checks++; if (sc !== FULL) begin n_fail++; $display("FAIL sdiv_lat: got %0d want %0d", sc, FULL); end
        n_checks++; if (quotient !== 32'hFFFFFFF2) begin n_fail++; $display("FAIL sdiv_q: got %h want fffffff2", quotient); end
        n_checks++; if (remainder !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL sdiv_r: got %h want fffffffe", remainder); end
        end_instr();
        @(posedge clk); #1;
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, sc);
        n_checks++; if (quotient !== 32'h80000000) begin n_fail++; $display("FAIL sovf_q: got %h want 80000000", quotient); end
        n_checks++; if (remainder !== 32'h0) begin n_fail++; $display("FAIL sovf_r: got %h want 0", remainder); end
        end_instr();
        @(posedge clk); #1;
        // signed dividend positive, divisor negative: 100 / -7 = -14 r 2
        run_div(1'b1, 32'd100, 32'hFFFFFFF9, sc);
        n_checks++; if (quotient !== 32'hFFFFFFF2) begin n_fail++; $display("FAIL sdiv2_q: got %h want fffffff2", quotient); end
        n_checks++; if (remainder !== 32'd2) begin n_fail++; $display("FAIL sdiv2_r: got %h want 2", remainder); end
        end_instr();
        @(posedge clk); #1;
    endtask

    task automatic test_div_zero();
        int sc;
        run_div(1'b0, 32'd5, 32'd0, sc);
        n_checks++; if (sc !== FASTLAT) begin n_fail++; $display("FAIL dz_lat: got %0d want %0d", sc, FASTLAT); end
        n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL dz_valid: got %b want 1", valid); end
        n_checks++; if (quotient !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL dz_q: got %h want ffffffff", quotient); end
        n_checks++; if (remainder !== 32'd5) begin n_fail++; $display("FAIL dz_r: got %h want 5", remainder); end
        end_instr();
        @(posedge clk); #1;
        run_div(1'b0, 32'd3, 32'd9, sc);
        n_checks++; if (sc !== FASTLAT) begin n_fail++; $display("FAIL small_lat: got %0d want %0d", sc, FASTLAT); end
        n_checks++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL small_q: got %h want 0", quotient); end
        n_checks++; if (remainder !== 32'd3) begin n_fail++; $display("FAIL small_r: got %h want 3", remainder); end
        end_instr();
        @(posedge clk); #1;
    endtask

    task automatic test_hold();
        is_signed = 1'b0; a = 32'd1000; b = 32'd10;
        for (int c = 0; c < 44; c++) begin
            hold  = (c >= 30 && c <= 40);
            start = (c <= 41);
            @(negedge clk);
            if (c <= 32) begin
                n_checks++; if (stall !== 1'b1 || valid !== 1'b0) begin n_fail++; $display("FAIL hold_busy c=%0d: got stall=%b valid=%b want 1 0", c, stall, valid); end
            end else if (c <= 41) begin
                n_checks++; if (stall !== 1'b0 || valid !== 1'b1) begin n_fail++; $display("FAIL hold_done c=%0d: got stall=%b valid=%b want 0 1", c, stall, valid); end
                n_checks++; if (quotient !== 32'd100 || remainder !== 32'd0) begin n_fail++; $display("FAIL hold_res c=%0d: got %h/%h want 64/0", c, quotient, remainder); end
            end else begin
                n_checks++; if (stall !== 1'b0 || valid !== 1'b0) begin n_fail++; $display("FAIL hold_idle c=%0d: got stall=%b valid=%b want 0 0", c, stall, valid); end
            end
            @(posedge clk); #1;
        end
        hold = 1'b0; start = 1'b0;
    endtask

    task automatic test_flush();
        int sc;
        is_signed = 1'b0; a = 32'd1000; b = 32'd3;
        for (int c = 0; c < 14; c++) begin
            flush = (c == 10);
            start = (c < 10);
            @(negedge clk);
            n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid c=%0d: got %b want 0", c, valid); end
            n_checks++; if (stall !== (c < 10)) begin n_fail++; $display("FAIL flush_stall c=%0d: got %b want %b", c, stall, (c < 10)); end
            @(posedge clk); #1;
        end
        flush = 1'b0;
        run_div(1'b0, 32'd84, 32'd4, sc);
        n_checks++; if (sc !== FULL) begin n_fail++; $display("FAIL postflush_lat: got %0d want %0d", sc, FULL); end
        n_checks++; if (quotient !== 32'd21 || remainder !== 32'd0) begin n_fail++; $display("FAIL postflush_res: got %h/%h want 15/0", quotient, remainder); end
        end_instr();
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        int sc;
        start = 1'b1; is_signed = 1'b0; a = 32'd1000; b = 32'd7;
        repeat (5) begin @(posedge clk); #1; end
        @(negedge clk); #1;
        resetn = 1'b0;
        #1;
        n_checks++; if (stall !== 1'b0 || valid !== 1'b0) begin n_fail++; $display("FAIL arst_ctl: got stall=%b valid=%b want 0 0", stall, valid); end
        n_checks++; if (quotient !== 32'h0 || remainder !== 32'h0) begin n_fail++; $display("FAIL arst_res: got %h/%h want 0/0", quotient, remainder); end
        start = 1'b0;
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        run_div(1'b0, 32'd1000, 32'd7, sc);
        n_checks++; if (sc !== FULL) begin n_fail++; $display("FAIL arst_lat: got %0d want %0d", sc, FULL); end
        n_checks++; if (quotient !== 32'd142 || remainder !== 32'd6) begin n_fail++; $display("FAIL arst_res2: got %h/%h want 8e/6", quotient, remainder); end
        end_instr();
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int sc;
        run_div(1'b0, 32'd1000, 32'd10, sc);
        n_checks++; if (quotient !== 32'd100 || remainder !== 32'd0) begin n_fail++; $display("FAIL b2b_first: got %h/%h want 64/0", quotient, remainder); end
        @(posedge clk); #1;
        run_div(1'b0, 32'hFFFFFFFF, 32'd16, sc);
        n_checks++; if (sc !== FULL) begin n_fail++; $display("FAIL b2b_lat: got %0d want %0d", sc, FULL); end
        n_checks++; if (quotient !== 32'h0FFFFFFF || remainder !== 32'd15) begin n_fail++; $display("FAIL b2b_second: got %h/%h want 0fffffff/f", quotient, remainder); end
        end_instr();
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_div_signed();
        test_hold();
        test_flush();
        test_div_zero();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
- Multi-cycle integer divider in the execute stage.
- Responder side of the execute-stage stall protocol: it drives the stall that the hazard unit consumes as the ALU stall.
- Honours pipeline hold (cache stall) and exception flush.
- Produces the quotient and remainder for DIV and DIVU, which are written to HI/LO downstream.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  pipeline clock
- resetn  input  1  asynchronous active-low reset
- start  input  1  a divide instruction is present in the execute stage (held while the instruction stays in E)
- is_signed  input  1  1 = DIV, 0 = DIVU; sampled with start
- a  input  WIDTH  dividend; sampled with start
- b  input  WIDTH  divisor; sampled with start
- hold  input  1  downstream pipeline stalled (I- or D-cache stall); result must be held
- flush  input  1  exception flush; aborts the operation
- stall  output  1  drives the execute-stage ALU stall
- valid  output  1  quotient/remainder valid for the instruction currently in E
- quotient  output  WIDTH  quotient
- remainder  output  WIDTH  remainder

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (resetn low, asynchronous):
  - state = IDLE, counter = 0, all internal registers = 0.
  - valid = 0, quotient = 0, remainder = 0; stall = 0 whenever flush or reset is active.
- stall is combinational: stall = ~flush & ((IDLE & start) | BUSY).
- IDLE:
  - start=1 & flush=0: latch operands and go to BUSY.
  - For signed operations, operands are converted to magnitudes; the quotient sign (a[MSB]^b[MSB]) and remainder sign (a[MSB]) are saved.
  - Otherwise stay in IDLE.
- BUSY:
  - One radix-2 restoring step per cycle: shift the partial remainder left, trial-subtract the divisor, set the quotient bit when the result is non-negative.
  - counter increments each step; after step WIDTH-1 go to DONE and apply sign correction (two's-complement negate where the sign flag is set).
  - The BUSY state runs regardless of hold.
- Latency: start seen in cycle 0 → stall high in cycles 0..WIDTH (33 cycles for WIDTH=32) → cycle WIDTH+1: stall=0, valid=1, results stable.
- DONE:
  - stall=0, valid=1, outputs held.
  - hold=1: stay in DONE; the same instruction remains in E and must not re-trigger a divide.
  - hold=0: the instruction advances; go to IDLE next cycle and drop valid.
  - A back-to-back divide arriving in IDLE starts normally.
- flush=1 in any state: go to IDLE next cycle and drop valid.
  - Flush overrides start in the same cycle; no operand latch occurs.
- Divide by zero (b=0): completes with normal latency; quotient = all ones, remainder = a.
  - Signed correction is not applied to this result; software must not rely on it.
- Signed overflow (a = 0x80000000, b = 0xFFFFFFFF): quotient = 0x80000000, remainder = 0. This falls out naturally from magnitude arithmetic mod 2^WIDTH.
- Widths:
  - Partial remainder is WIDTH+1 bits.
  - All arithmetic is modulo 2^WIDTH on the outputs.
  - The counter saturates, never wraps, in DONE.

Optional Feature:
- Macro: DIV_FAST_BYPASS_EN.
- Defined: in IDLE with start & ~flush, if b=0 or |a| < |b| (magnitude compare), go directly to DONE.
  - stall is high in cycle 0 only; valid=1 in cycle 1.
  - Result: quotient=0 and remainder=a, or the divide-by-zero values above.
- Undefined: every operation takes the full WIDTH-step path; bypass compare logic is absent.

Test Plan:
- DIVU a=100, b=7, hold=0 → stall high exactly 33 cycles; then valid=1, quotient=14, remainder=2; IDLE the following cycle.
- DIV a=-100 (0xFFFFFF9C), b=7 → quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2); DIV a=0x80000000, b=-1 → quotient=0x80000000, remainder=0.
- DIVU a=5, b=0 → quotient=0xFFFFFFFF, remainder=5. With DIV_FAST_BYPASS_EN: stall high 1 cycle only. Same bypass holds for a=3, b=9 → quotient=0, remainder=3.
- DIVU 1000/10 with hold=1 asserted from cycle 30 to 40 → completion at cycle 33 unaffected; DONE held with valid=1 and stall=0 through cycle 40; no restart; IDLE at cycle 42.
- flush pulse at cycle 10 of a divide → stall=0 in cycle 10, IDLE in cycle 11, valid never asserted. Next start (84/4) → quotient=21, remainder=0.
- resetn asserted low mid-BUSY (asynchronous, between clock edges) → stall=0, valid=0, quotient=0, remainder=0 immediately. After release, a divide completes normally.
